// File: rtl/mult_feeder.sv
// mult_feeder: buffers operand pairs and sequences them one at a time
// into an iterative multiplier, short-circuiting pairs with a zero operand.
module mult_feeder #(
  parameter int N     = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_a,
  input  logic [N-1:0]           in_b,
  output logic                   mult_start,
  output logic [N-1:0]           mult_a,
  output logic [N-1:0]           mult_b,
  input  logic                   mult_done,
  input  logic [2*N-1:0]         mult_prod,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*N-1:0]         out_prod,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  state_t         state;
  logic [N-1:0]   mem_a [DEPTH];
  logic [N-1:0]   mem_b [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [N-1:0]   head_a;
  logic [N-1:0]   head_b;
  logic           head_zero;
  logic           push;
  logic           pop;

  assign in_ready  = (count != (AW+1)'(DEPTH));
  assign push      = in_valid && in_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign head_a    = mem_a[rd_ptr];
  assign head_b    = mem_b[rd_ptr];
  assign head_zero = (head_a == '0) || (head_b == '0);
  assign busy      = (state != IDLE);

  // storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      mult_start <= 1'b0;
      mult_a     <= '0;
      mult_b     <= '0;
      out_valid  <= 1'b0;
      out_prod   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            if (head_zero) begin
              out_prod  <= '0;
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              mult_a     <= head_a;
              mult_b     <= head_b;
              mult_start <= 1'b1;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mult_start <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          if (mult_done) begin
            out_prod  <= mult_prod;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_feeder.sv
// tb_mult_feeder: directed vectors against a scoreboard, with a small
// behavioural multiplier answering the start/done handshake.
module tb_mult_feeder;

  localparam int N     = 2;
  localparam int DEPTH = 4;

  logic         clk = 0;
  logic         rst = 0;
  logic         in_valid = 0;
  logic         in_ready;
  logic [N-1:0] in_a = '0;
  logic [N-1:0] in_b = '0;
  logic         mult_start;
  logic [N-1:0] mult_a;
  logic [N-1:0] mult_b;
  logic         mult_done;
  logic [3:0]   mult_prod;
  logic         out_valid;
  logic         out_ready = 0;
  logic [3:0]   out_prod;
  logic         busy;
  logic [2:0]   count;

  mult_feeder #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_done(mult_done), .mult_prod(mult_prod),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int valid_cycles = 0;
  int hs_cnt = 0;
  logic [N-1:0] last_a, last_b;
  logic [3:0] exp_q[$];

  // multiplier model: done pulses in the mdelay-th WAIT cycle (0 = never)
  int   mdelay = 3;
  int   mcnt;
  logic model_done;
  logic stray_done = 0;
  assign mult_done = model_done | stray_done;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcnt       <= 0;
      model_done <= 0;
      mult_prod  <= '0;
    end else begin
      model_done <= 0;
      if (mult_start) begin
        mult_prod <= {2'b00, mult_a} * {2'b00, mult_b};
        if (mdelay == 1) model_done <= 1;
        else if (mdelay > 1) mcnt <= mdelay - 1;
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) model_done <= 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (mult_start) begin
        start_cnt++;
        last_a = mult_a;
        last_b = mult_b;
      end
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) begin
        hs_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got %0d expected none", out_prod);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (out_prod !== e) begin
            errors++;
            $display("FAIL result: got %0d expected %0d", out_prod, e);
          end
        end
      end
    end
  end

  // drive one pair before the next edge; returns just after that edge
  task automatic push(input int a, input int b, input int e, input bit sb);
    @(negedge clk);
    check("push_ready", in_ready, 1);
    in_valid = 1;
    in_a = N'(a);
    in_b = N'(b);
    if (sb) exp_q.push_back(4'(e));
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain(input string name);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && count == 0 && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  initial begin
    int s0, v0, h0;
    bit stable;

    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_prod", out_prod, 0);
    check("rst_mult", {mult_start, mult_a, mult_b}, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1;

    // normal product
    out_ready = 1;
    mdelay = 3;
    s0 = start_cnt; v0 = valid_cycles;
    push(3, 2, 6, 1);
    drain("normal_drain");
    check("normal_starts", start_cnt - s0, 1);
    check("normal_a", last_a, 3);
    check("normal_b", last_b, 2);
    check("normal_valid_cycles", valid_cycles - v0, 1);

    // zero bypass
    s0 = start_cnt;
    push(0, 3, 0, 1);
    check("zero1_count", count, 1);
    @(negedge clk);
    check("zero1_valid", out_valid, 1);
    drain("zero1_drain");
    push(2, 0, 0, 1);
    @(negedge clk);
    check("zero2_valid", out_valid, 1);
    drain("zero2_drain");
    check("zero_no_start", start_cnt - s0, 0);

    // full FIFO
    out_ready = 0;
    @(negedge clk);
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      logic [N-1:0] va [5];
      logic [N-1:0] vb [5];
      logic [3:0]   vp [5];
      va = '{1, 1, 1, 2, 3};
      vb = '{1, 2, 3, 2, 3};
      vp = '{1, 2, 3, 4, 9};
      in_a = va[i];
      in_b = vb[i];
      exp_q.push_back(vp[i]);
      @(negedge clk);
    end
    in_valid = 0;
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    out_ready = 1;
    drain("full_drain");

    // simultaneous push and pop
    mdelay = 1;
    @(negedge clk);
    in_valid = 1; in_a = 2; in_b = 3; exp_q.push_back(6);
    @(negedge clk);
    check("pp_count_first", count, 1);
    in_a = 3; in_b = 1; exp_q.push_back(3);
    @(negedge clk);
    in_valid = 0;
    check("pp_count_same", count, 1);
    drain("pp_drain");

    // reset in WAIT
    mdelay = 0;
    h0 = hs_cnt;
    push(3, 3, 9, 0);
    @(negedge clk);
    @(negedge clk);
    check("rw_busy_before", busy, 1);
    rst = 0;
    #1;
    check("rw_busy", busy, 0);
    check("rw_count", count, 0);
    check("rw_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1;
    stray_done = 1;
    @(negedge clk);
    stray_done = 0;
    @(negedge clk);
    check("rw_stray_valid", out_valid, 0);
    check("rw_stray_busy", busy, 0);
    check("rw_no_result", hs_cnt - h0, 0);

    // late done
    mdelay = 11;
    h0 = hs_cnt;
    push(3, 2, 6, 1);
    @(negedge clk);
    check("late_start", mult_start, 1);
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy || mult_a != 3 || mult_b != 2 || out_valid) stable = 0;
    end
    check("late_stable", stable, 1);
    drain("late_drain");
    check("late_results", hs_cnt - h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
